// File: rtl/cic_interp_integrator_if.sv
// Low-rate input handshake and high-rate output bundle for cic_interp_integrator.
//   in_data   : comb-chain output sample, two's complement
//   in_valid  : in_data holds a sample
//   in_ready  : block takes a sample this clk
//   out_data  : interpolated sample, two's complement
//   out_valid : one-clk pulse when out_data is refreshed
// master = comb-chain/consumer side, slave = the integrator block.
interface cic_interp_integrator_if #(
  parameter int BITWIDTH  = 32,
  parameter int OUT_WIDTH = 16
);
  logic [BITWIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;

  modport master (output in_data, output in_valid,
                  input  in_ready, input out_data, input out_valid);
  modport slave  (input  in_data, input in_valid,
                  output in_ready, output out_data, output out_valid);
endinterface

// File: rtl/cic_interp_integrator.sv
// High-rate half of a CIC interpolator: zero-stuffs the low-rate comb output by
// RATIO and runs it through N_STAGES wrapping integrators, one step per ena tick.
// The output takes the top OUT_WIDTH bits of the last integrator.
// Ports:
//   clk      : system clock
//   rst      : asynchronous reset, active low
//   ena      : high-rate tick, one clk wide, one per output sample
//   bus      : slave side of cic_interp_integrator_if (in_*/out_* signals)
//   phase    : zero-stuff phase, 0..RATIO-1
//   underrun : sticky, a phase-0 tick found no valid input
// Build option: define CIC_ROUND_EN to round half-up on the dropped LSBs with
// saturation at +max; left undefined, the output is plain truncation.
module cic_interp_integrator #(
  parameter int BITWIDTH  = 32,
  parameter int N_STAGES  = 3,
  parameter int RATIO     = 8,
  parameter int OUT_WIDTH = 16,
  localparam int PW       = $clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  cic_interp_integrator_if.slave bus,
  output logic [PW-1:0]         phase,
  output logic                  underrun
);

  localparam logic [PW-1:0] PH_LAST = PW'(RATIO - 1);

  logic [PW-1:0]        phase_q, phase_d;
  logic [BITWIDTH-1:0]  int_q [N_STAGES];
  logic [BITWIDTH-1:0]  int_d [N_STAGES];
  logic                 ena_q, ena_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 underrun_q, underrun_d;

  logic                 in_ready_c;
  logic                 take;
  logic [BITWIDTH-1:0]  x;
  logic [OUT_WIDTH-1:0] out_next;

`ifdef CIC_ROUND_EN
  if (OUT_WIDTH < BITWIDTH) begin : g_round
    localparam logic [OUT_WIDTH-1:0] MAXPOS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    logic [OUT_WIDTH-1:0] trunc;
    logic                 rnd;
    assign trunc = int_q[N_STAGES-1][BITWIDTH-1 -: OUT_WIDTH];
    assign rnd   = int_q[N_STAGES-1][BITWIDTH-OUT_WIDTH-1];
    // Adding one can only overflow from +max; negative values never overflow.
    assign out_next = (rnd && (trunc == MAXPOS)) ? MAXPOS : trunc + OUT_WIDTH'(rnd);
  end else begin : g_full
    assign out_next = int_q[N_STAGES-1][BITWIDTH-1 -: OUT_WIDTH];
  end
`else
  assign out_next = int_q[N_STAGES-1][BITWIDTH-1 -: OUT_WIDTH];
`endif

  always_comb begin
    // Gated by rst so in_ready reads 0 while the block is held in reset.
    in_ready_c  = rst && ena && (phase_q == '0);
    take        = in_ready_c && bus.in_valid;
    x           = take ? bus.in_data : '0;

    phase_d     = phase_q;
    int_d       = int_q;
    underrun_d  = underrun_q;
    ena_d       = ena;
    out_valid_d = ena_q;
    out_data_d  = ena_q ? out_next : out_data_q;

    if (ena) begin
      phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      int_d[0] = int_q[0] + x;
      // Each stage uses the previous stage's pre-tick value: one tick per stage.
      for (int k = 1; k < N_STAGES; k++) begin
        int_d[k] = int_q[k] + int_q[k-1];
      end
      if ((phase_q == '0) && !bus.in_valid) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q     <= '0;
      int_q       <= '{default: '0};
      ena_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      int_q       <= int_d;
      ena_q       <= ena_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign phase         = phase_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_cic_interp_integrator.sv
module tb_cic_interp_integrator;

  localparam int N_A = 2;

`ifdef CIC_ROUND_EN
  localparam logic [7:0] R_LO = 8'h02;
`else
  localparam logic [7:0] R_LO = 8'h01;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic [1:0] phase_a, phase_w, phase_r;
  logic underrun_a, underrun_w, underrun_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cic_interp_integrator_if #(.BITWIDTH(16), .OUT_WIDTH(16)) bus_a ();
  cic_interp_integrator_if #(.BITWIDTH(16), .OUT_WIDTH(16)) bus_w ();
  cic_interp_integrator_if #(.BITWIDTH(16), .OUT_WIDTH(8))  bus_r ();

  cic_interp_integrator #(.BITWIDTH(16), .N_STAGES(N_A), .RATIO(4), .OUT_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus_a), .phase(phase_a), .underrun(underrun_a));
  cic_interp_integrator #(.BITWIDTH(16), .N_STAGES(1), .RATIO(4), .OUT_WIDTH(16)) u_w (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus_w), .phase(phase_w), .underrun(underrun_w));
  cic_interp_integrator #(.BITWIDTH(16), .N_STAGES(1), .RATIO(4), .OUT_WIDTH(8)) u_r (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus_r), .phase(phase_r), .underrun(underrun_r));

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        exp_rdy;
    logic [15:0] exp_out;
    logic [15:0] dw;
    logic [15:0] exp_w;
    logic [15:0] dr;
    logic [7:0]  exp_r;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    if (n < k) return 0;
    for (int t = 0; t < k; t++) r = r * (n - t) / (t + 1);
    return r;
  endfunction

  // One high-rate tick: ena for one clk, then one idle clk; ends #1 after the
  // clk where out_valid is expected high.
  task automatic tick(output logic rdy_on, output logic rdy_off, output logic ov_mid);
    @(negedge clk); ena = 1'b1; #1 rdy_on = bus_a.in_ready;
    @(posedge clk); #1 ov_mid = bus_a.out_valid;
    @(negedge clk); ena = 1'b0; #1 rdy_off = bus_a.in_ready;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  // Reference: after tick n, stage k holds sum_i x[i]*C(n-i, k), mod 2^BITWIDTH.
  task automatic run_random(input int nticks, input bit all_valid, output int xfers);
    longint xs[$];
    logic   exp_under, r_on, r_off, ovm, v;
    logic [15:0] d;
    longint acc;
    do_reset();
    xfers = 0;
    exp_under = 1'b0;
    for (int i = 0; i < nticks; i++) begin
      v = all_valid ? 1'b1 : ($urandom_range(0, 4) != 0);
      d = 16'($urandom);
      bus_a.in_valid = v;
      bus_a.in_data  = d;
      tick(r_on, r_off, ovm);
      if (r_on && v) xfers++;
      check("ready_on_tick", r_on, ((i % 4) == 0));
      check("ready_off_tick", r_off, 0);
      check("valid_mid", ovm, 0);
      if ((i % 4) == 0 && v) xs.push_back(longint'(d));
      else xs.push_back(0);
      if ((i % 4) == 0 && !v) exp_under = 1'b1;
      acc = 0;
      for (int j = 0; j <= i; j++) acc += xs[j] * binom(i - j, N_A - 1);
      check("model_out", bus_a.out_data, acc[15:0]);
      check("model_valid", bus_a.out_valid, 1);
      check("model_underrun", underrun_a, exp_under);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1);
  end

  initial begin
    logic r_on, r_off, ovm;
    int   xf;

    tbl[0] = '{1'b1, 16'h0001, 1'b1, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0180, R_LO};
    tbl[1] = '{1'b1, 16'h0005, 1'b0, 16'h0001, 16'h1234, 16'h7FFF, 16'h5555, R_LO};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 16'h0002, 16'h1234, 16'h7FFF, 16'h5555, R_LO};
    tbl[3] = '{1'b0, 16'h0009, 1'b0, 16'h0003, 16'h1234, 16'h7FFF, 16'h5555, R_LO};
    tbl[4] = '{1'b1, 16'h0000, 1'b1, 16'h0004, 16'h7FFF, 16'hFFFE, 16'h7E40, 8'h7F};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 16'h0005, 16'h1234, 16'hFFFE, 16'h5555, 8'h7F};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 16'h0006, 16'h1234, 16'hFFFE, 16'h5555, 8'h7F};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 16'h0007, 16'h1234, 16'hFFFE, 16'h5555, 8'h7F};

    rst = 1'b0; ena = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_w.in_valid = 1'b0; bus_w.in_data = '0;
    bus_r.in_valid = 1'b0; bus_r.in_data = '0;

    #1;
    check("por_out_data", bus_a.out_data, 0);
    check("por_out_valid", bus_a.out_valid, 0);
    check("por_phase", phase_a, 0);
    check("por_underrun", underrun_a, 0);
    ena = 1'b1; #1;
    check("por_in_ready", bus_a.in_ready, 0);
    ena = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;

    // Impulse, handshake ignore, wrap and rounding, ticks aligned after reset.
    for (int i = 0; i < 8; i++) begin
      bus_a.in_valid = tbl[i].v; bus_a.in_data = tbl[i].d;
      bus_w.in_valid = 1'b1;     bus_w.in_data = tbl[i].dw;
      bus_r.in_valid = 1'b1;     bus_r.in_data = tbl[i].dr;
      tick(r_on, r_off, ovm);
      check($sformatf("imp_ready[%0d]", i), r_on, tbl[i].exp_rdy);
      check($sformatf("imp_valid_mid[%0d]", i), ovm, 0);
      check($sformatf("imp_out[%0d]", i), bus_a.out_data, tbl[i].exp_out);
      check($sformatf("imp_valid[%0d]", i), bus_a.out_valid, 1);
      check($sformatf("imp_phase[%0d]", i), phase_a, (i + 1) % 4);
      check($sformatf("wrap_out[%0d]", i), bus_w.out_data, tbl[i].exp_w);
      check($sformatf("round_out[%0d]", i), bus_r.out_data, tbl[i].exp_r);
    end
    check("imp_underrun", underrun_a, 0);
    bus_w.in_valid = 1'b0; bus_r.in_valid = 1'b0;

    // Valid held high: one transfer per four ticks.
    run_random(12, 1'b1, xf);
    check("hs_transfers", xf, 3);

    // Random valid/data against the reference model.
    run_random(64, 1'b0, xf);

    // Underrun is sticky through resumed valid data.
    do_reset();
    bus_a.in_valid = 1'b0; bus_a.in_data = 16'h0042;
    tick(r_on, r_off, ovm);
    check("ur_set", underrun_a, 1);
    for (int i = 1; i < 10; i++) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = 16'(i * 3);
      tick(r_on, r_off, ovm);
      check($sformatf("ur_hold[%0d]", i), underrun_a, 1);
    end
    check("ur_pre_rst_out_nonzero", (bus_a.out_data != 0), 1);
    check("ur_pre_rst_phase", phase_a, 2);

    // Mid-stream reset for one clk.
    @(negedge clk); rst = 1'b0; ena = 1'b1; #1;
    check("rst_out_data", bus_a.out_data, 0);
    check("rst_phase", phase_a, 0);
    check("rst_underrun", underrun_a, 0);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_in_ready", bus_a.in_ready, 0);
    @(negedge clk); rst = 1'b1; ena = 1'b0; #1;
    check("rel_in_ready", bus_a.in_ready, 0);
    check("rel_phase", phase_a, 0);
    bus_a.in_valid = 1'b1; bus_a.in_data = 16'h0010;
    tick(r_on, r_off, ovm);
    check("rel_first_ready", r_on, 1);
    check("rel_out0", bus_a.out_data, 0);
    bus_a.in_data = 16'h0777;
    tick(r_on, r_off, ovm);
    check("rel_out1", bus_a.out_data, 16'h0010);
    tick(r_on, r_off, ovm);
    check("rel_out2", bus_a.out_data, 16'h0020);
    check("rel_underrun", underrun_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
